hum_ctrl_fsm: RTL and testbench



---
 rtl/hum_ctrl_pkg.sv | 14 +
 rtl/step_tick_gen.sv | 38 +++
 rtl/hum_ctrl_fsm.sv | 150 +++++++++++++++
 tb/tb_hum_ctrl_fsm.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hum_ctrl_pkg.sv
// Shared types and constants for the closed-loop humidity regulator.
package hum_ctrl_pkg;

  localparam int unsigned HUM_W   = 8;
  localparam int unsigned MAX_HUM = 100;

  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StStable     = 2'd1,
    StHumidify   = 2'd2,
    StDehumidify = 2'd3
  } hum_ctrl_state_t;

endpackage

// File: rtl/step_tick_gen.sv
// Step-rate prescaler: counts 0..STEP_DIV-1 and flags the last count as a tick.
// While i_clr is high the count is held at zero so the first tick after release
// lands STEP_DIV cycles later.
module step_tick_gen #(
  parameter int unsigned STEP_DIV = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned     CntW    = 8;
  localparam logic [CntW-1:0] LastCnt = CntW'(STEP_DIV - 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;

  // Next count: wrap after the last value, hold at zero while cleared.
  always_comb begin
    w_cnt_next = r_cnt + CntW'(1);
    if (i_clr || (r_cnt == LastCnt)) begin
      w_cnt_next = '0;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign o_tick = !i_clr && (r_cnt == LastCnt);

endmodule

// File: rtl/hum_ctrl_fsm.sv
// Humidity regulator: compares the measured humidity with a clamped target and a
// hysteresis band, then issues rate-limited single-cycle step pulses to the plant.
// A sticky alarm flags episodes that need ALARM_STEPS or more steps.
module hum_ctrl_fsm
  import hum_ctrl_pkg::*;
#(
  parameter int unsigned STEP_DIV    = 16,
  parameter int unsigned HYST        = 2,
  parameter int unsigned ALARM_STEPS = 64
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             ctrl_en,
  input  logic [HUM_W-1:0] target_hum,
  input  logic [HUM_W-1:0] real_time_hum,
  output logic             hum_inc_en,
  output logic             hum_dec_en,
  output logic [1:0]       ctrl_state,
  output logic             at_target,
  output logic             alarm
);

  localparam int unsigned      W9         = HUM_W + 1;
  localparam int unsigned      EpW        = $clog2(ALARM_STEPS + 1);
  localparam logic [HUM_W-1:0] MaxHum     = HUM_W'(MAX_HUM);
  localparam logic [W9-1:0]    Hyst9      = W9'(HYST);
  localparam logic [EpW-1:0]   AlarmSteps = EpW'(ALARM_STEPS);

  hum_ctrl_state_t  r_state;
  hum_ctrl_state_t  w_next;
  logic [HUM_W-1:0] w_tgt;
  logic [W9-1:0]    w_tgt9;
  logic [W9-1:0]    w_hum9;
  logic [W9-1:0]    w_lo;
  logic [W9-1:0]    w_hi;
  logic             w_clr;
  logic             w_tick;
  logic             w_inc_d;
  logic             w_dec_d;
  logic             w_pulse;
  logic             r_inc;
  logic             r_dec;
  logic             r_at_target;
  logic             r_alarm;
  logic [EpW-1:0]   r_ep_cnt;
  logic [EpW-1:0]   w_ep_next;

  // Clamp the target and derive the band edges in 9 bits so hi never wraps
  // and lo floors at zero for small targets.
  always_comb begin
    w_tgt  = (target_hum > MaxHum) ? MaxHum : target_hum;
    w_tgt9 = {1'b0, w_tgt};
    w_hum9 = {1'b0, real_time_hum};
    w_hi   = w_tgt9 + Hyst9;
    w_lo   = (w_tgt9 >= Hyst9) ? (w_tgt9 - Hyst9) : '0;
  end

  // Next-state logic; direction reversals always pass through STABLE.
  always_comb begin
    w_next = r_state;
    if (!ctrl_en) begin
      w_next = StIdle;
    end else begin
      case (r_state)
        StIdle: w_next = StStable;
        StStable: begin
          if (w_hum9 < w_lo) begin
            w_next = StHumidify;
          end else if (w_hum9 > w_hi) begin
            w_next = StDehumidify;
          end
        end
        StHumidify: begin
          if (w_hum9 >= w_tgt9) w_next = StStable;
        end
        StDehumidify: begin
          if (w_hum9 <= w_tgt9) w_next = StStable;
        end
        default: w_next = StIdle;
      endcase
    end
  end

  // The prescaler only runs while actively stepping, so each episode starts fresh.
  assign w_clr = (r_state == StIdle) || (r_state == StStable);

  step_tick_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_step_tick_gen (
    .pclk   (pclk),
    .preset (preset),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  // Pulse requests; the range guards keep the plant's 8-bit value from wrapping.
  always_comb begin
    w_inc_d = w_tick && (r_state == StHumidify) && ctrl_en && (real_time_hum < MaxHum);
    w_dec_d = w_tick && (r_state == StDehumidify) && ctrl_en && (real_time_hum != '0);
  end

  // State register plus registered pulse and at-target outputs.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state     <= StIdle;
      r_inc       <= 1'b0;
      r_dec       <= 1'b0;
      r_at_target <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_inc       <= w_inc_d;
      r_dec       <= w_dec_d;
      r_at_target <= (w_next == StStable);
    end
  end

  assign w_pulse = r_inc || r_dec;

  // Episode step count: cleared whenever the loop is settled or idle, saturating.
  always_comb begin
    w_ep_next = r_ep_cnt;
    if ((w_next == StIdle) || (w_next == StStable)) begin
      w_ep_next = '0;
    end else if (w_pulse && (r_ep_cnt != AlarmSteps)) begin
      w_ep_next = r_ep_cnt + EpW'(1);
    end
  end

  // Episode counter and sticky alarm; only disabling the loop or reset clears the alarm.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_ep_cnt <= '0;
      r_alarm  <= 1'b0;
    end else begin
      r_ep_cnt <= w_ep_next;
      if (!ctrl_en) begin
        r_alarm <= 1'b0;
      end else if (w_ep_next == AlarmSteps) begin
        r_alarm <= 1'b1;
      end
    end
  end

  assign hum_inc_en = r_inc;
  assign hum_dec_en = r_dec;
  assign ctrl_state = r_state;
  assign at_target  = r_at_target;
  assign alarm      = r_alarm;

endmodule

// File: tb/tb_hum_ctrl_fsm.sv
// Self-checking bench for hum_ctrl_fsm with a simple integrating plant model.
module tb_hum_ctrl_fsm;

  localparam int unsigned StepDiv    = 4;
  localparam int unsigned Hyst       = 2;
  localparam int unsigned AlarmSteps = 8;
  localparam int          NumVec     = 11;

  typedef struct {
    logic [7:0] tgt;
    logic [7:0] hum;
    int         exp_state;
  } vec_t;

  logic       clk = 1'b0;
  logic       preset;
  logic       ctrl_en;
  logic [7:0] target_hum;
  logic [7:0] rt_hum;
  logic       hum_inc_en;
  logic       hum_dec_en;
  logic [1:0] ctrl_state;
  logic       at_target;
  logic       alarm;

  // Plant: reset value 50, moves by one a cycle after each pulse while connected.
  logic [7:0] plant_hum = 8'd50;
  logic       plant_conn;
  logic       plant_load;
  logic [7:0] plant_load_val;
  logic [7:0] forced_hum;

  int         cyc       = 0;
  int         inc_total = 0;
  int         dec_total = 0;
  int         both_cnt  = 0;
  logic [7:0] hum_max   = 8'd0;

  int         n_checks = 0;
  int         n_errors = 0;
  int         state_q[$];
  int         pulse_q[$];
  vec_t       vecs[NumVec];

  assign rt_hum = plant_conn ? plant_hum : forced_hum;

  hum_ctrl_fsm #(
    .STEP_DIV    (StepDiv),
    .HYST        (Hyst),
    .ALARM_STEPS (AlarmSteps)
  ) dut (
    .pclk          (clk),
    .preset        (preset),
    .ctrl_en       (ctrl_en),
    .target_hum    (target_hum),
    .real_time_hum (rt_hum),
    .hum_inc_en    (hum_inc_en),
    .hum_dec_en    (hum_dec_en),
    .ctrl_state    (ctrl_state),
    .at_target     (at_target),
    .alarm         (alarm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preset === 1'b1) begin
      plant_hum <= 8'd50;
    end else if (plant_load === 1'b1) begin
      plant_hum <= plant_load_val;
    end else if (plant_conn && hum_inc_en === 1'b1 && plant_hum != 8'hFF) begin
      plant_hum <= plant_hum + 8'd1;
    end else if (plant_conn && hum_dec_en === 1'b1 && plant_hum != 8'h00) begin
      plant_hum <= plant_hum - 8'd1;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (hum_inc_en === 1'b1) inc_total <= inc_total + 1;
    if (hum_dec_en === 1'b1) dec_total <= dec_total + 1;
    if (hum_inc_en === 1'b1 && hum_dec_en === 1'b1) both_cnt <= both_cnt + 1;
    if (plant_hum > hum_max) hum_max <= plant_hum;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Step ncyc cycles; every observed pulse must match the next expected cycle number.
  task automatic run_pulses(input int ncyc, input bit watch_inc);
    logic p;
    for (int i = 0; i < ncyc; i++) begin
      step();
      p = watch_inc ? hum_inc_en : hum_dec_en;
      if (p === 1'b1) begin
        if (pulse_q.size() == 0) check("unexpected_pulse_cycle", cyc, -1);
        else check("pulse_cycle", cyc, pulse_q.pop_front());
      end
    end
    check("missing_pulses", pulse_q.size(), 0);
  endtask

  initial begin
    int exp_v;
    int e0;
    int i0;
    int d0;

    // Decision taken from STABLE for {target, hum}: 1=STABLE, 2=HUMIDIFY, 3=DEHUMIDIFY.
    vecs[0]  = '{8'd60,  8'd58,  1};
    vecs[1]  = '{8'd60,  8'd57,  2};
    vecs[2]  = '{8'd60,  8'd62,  1};
    vecs[3]  = '{8'd60,  8'd63,  3};
    vecs[4]  = '{8'd200, 8'd97,  2};
    vecs[5]  = '{8'd200, 8'd98,  1};
    vecs[6]  = '{8'd200, 8'd102, 1};
    vecs[7]  = '{8'd200, 8'd103, 3};
    vecs[8]  = '{8'd1,   8'd0,   1};
    vecs[9]  = '{8'd0,   8'd3,   3};
    vecs[10] = '{8'd0,   8'd2,   1};

    preset         = 1'b1;
    ctrl_en        = 1'b1;
    target_hum     = 8'd50;
    plant_conn     = 1'b1;
    plant_load     = 1'b0;
    plant_load_val = 8'd0;
    forced_hum     = 8'd0;

    // Reset behaviour.
    step();
    step();
    check("rst_state", int'(ctrl_state), 0);
    check("rst_inc", int'(hum_inc_en), 0);
    check("rst_dec", int'(hum_dec_en), 0);
    check("rst_at_target", int'(at_target), 0);
    check("rst_alarm", int'(alarm), 0);
    preset = 1'b0;
    step();
    step();
    check("post_rst_stable", int'(ctrl_state), 1);
    check("post_rst_at_target", int'(at_target), 1);

    // Band and clamp decisions from STABLE.
    plant_conn = 1'b0;
    for (int i = 0; i < NumVec; i++) begin
      ctrl_en    = 1'b0;
      target_hum = vecs[i].tgt;
      forced_hum = vecs[i].hum;
      step();
      ctrl_en = 1'b1;
      state_q.push_back(vecs[i].exp_state);
      step();
      step();
      exp_v = state_q.pop_front();
      check($sformatf("vec%0d_state", i), int'(ctrl_state), exp_v);
      check($sformatf("vec%0d_at_target", i), int'(at_target), int'(exp_v == 1));
    end

    // Settle at 50 with the plant in the loop.
    ctrl_en    = 1'b0;
    plant_conn = 1'b1;
    target_hum = 8'd50;
    step();
    ctrl_en = 1'b1;
    step();
    step();
    check("t2_pre_stable", int'(ctrl_state), 1);

    // Humidify 50 -> 60.
    i0 = inc_total;
    d0 = dec_total;
    target_hum = 8'd60;
    step();
    check("t2_enter_humidify", int'(ctrl_state), 2);
    e0 = cyc;
    for (int k = 1; k <= 10; k++) pulse_q.push_back(e0 + int'(StepDiv) * k);
    run_pulses(50, 1'b1);
    check("t2_hum", int'(plant_hum), 60);
    check("t2_state", int'(ctrl_state), 1);
    check("t2_at_target", int'(at_target), 1);
    check("t2_inc_count", inc_total - i0, 10);
    check("t2_dec_count", dec_total - d0, 0);
    // Ten steps is past ALARM_STEPS=8, so the sticky flag is up even in STABLE.
    check("t2_alarm_sticky", int'(alarm), 1);

    ctrl_en = 1'b0;
    step();
    check("t2_disable_idle", int'(ctrl_state), 0);
    check("t2_disable_alarm_clear", int'(alarm), 0);
    ctrl_en = 1'b1;
    step();
    step();
    check("t3_pre_stable", int'(ctrl_state), 1);

    // Retarget inside and then outside the band.
    i0 = inc_total;
    d0 = dec_total;
    target_hum = 8'd58;
    repeat (8) step();
    check("t3_in_band_state", int'(ctrl_state), 1);
    check("t3_in_band_steps", (inc_total - i0) + (dec_total - d0), 0);
    target_hum = 8'd57;
    step();
    check("t3_enter_dehumidify", int'(ctrl_state), 3);
    e0 = cyc;
    for (int k = 1; k <= 3; k++) pulse_q.push_back(e0 + int'(StepDiv) * k);
    run_pulses(20, 1'b0);
    check("t3_hum", int'(plant_hum), 57);
    check("t3_state", int'(ctrl_state), 1);
    check("t3_dec_count", dec_total - d0, 3);
    check("t3_inc_count", inc_total - i0, 0);
    check("t3_alarm", int'(alarm), 0);

    // Clamped target near the top: plant jumps to 98 mid-episode.
    i0 = inc_total;
    target_hum = 8'd200;
    step();
    check("t4_enter_humidify", int'(ctrl_state), 2);
    e0 = cyc;
    plant_load     = 1'b1;
    plant_load_val = 8'd98;
    step();
    plant_load = 1'b0;
    pulse_q.push_back(e0 + int'(StepDiv));
    pulse_q.push_back(e0 + 2 * int'(StepDiv));
    run_pulses(15, 1'b1);
    check("t4_hum", int'(plant_hum), 100);
    check("t4_state", int'(ctrl_state), 1);
    check("t4_inc_count", inc_total - i0, 2);
    check("t4_never_above_max", int'(hum_max <= 8'd100), 1);

    // Upper saturation guard: humidity hits 100 on the tick cycle.
    plant_conn = 1'b0;
    forced_hum = 8'd90;
    step();
    check("guard_enter_humidify", int'(ctrl_state), 2);
    repeat (3) step();
    forced_hum = 8'd100;
    step();
    check("guard_no_inc_at_max", int'(hum_inc_en), 0);
    check("guard_state", int'(ctrl_state), 1);

    // Stuck loop raises the alarm after the 8th pulse.
    forced_hum = 8'd40;
    target_hum = 8'd60;
    step();
    check("t5_enter_humidify", int'(ctrl_state), 2);
    e0 = cyc;
    for (int k = 1; k <= int'(AlarmSteps); k++) pulse_q.push_back(e0 + int'(StepDiv) * k);
    run_pulses(32, 1'b1);
    check("t5_alarm_on_8th_pulse", int'(alarm), 0);
    step();
    check("t5_alarm_after_8th", int'(alarm), 1);
    ctrl_en = 1'b0;
    step();
    check("t5_idle", int'(ctrl_state), 0);
    check("t5_alarm_cleared", int'(alarm), 0);
    i0 = inc_total;
    repeat (8) step();
    check("t5_no_pulses_idle", inc_total - i0, 0);

    // Disable on the tick cycle suppresses the pulse.
    ctrl_en = 1'b1;
    step();
    step();
    check("t6_enter_humidify", int'(ctrl_state), 2);
    repeat (3) step();
    ctrl_en = 1'b0;
    step();
    check("t6_disable_no_pulse", int'(hum_inc_en), 0);
    check("t6_disable_idle", int'(ctrl_state), 0);

    // Reset on the tick cycle drops the pending pulse.
    ctrl_en = 1'b1;
    step();
    step();
    check("t6_reenter_humidify", int'(ctrl_state), 2);
    repeat (3) step();
    preset = 1'b1;
    step();
    check("t6_rst_inc", int'(hum_inc_en), 0);
    check("t6_rst_dec", int'(hum_dec_en), 0);
    check("t6_rst_state", int'(ctrl_state), 0);
    check("t6_rst_at_target", int'(at_target), 0);
    check("t6_rst_alarm", int'(alarm), 0);
    preset = 1'b0;
    step();

    check("never_both_pulses", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
